gradient_mem_write_responder: RTL and testbench

Memory-side responder for the compressed gradient write stream. It accepts address/gradient writes on the `mem_valid`/`mem_ready` handshake and buffers them in a small FIFO. Entries drain at a programmable rate into an on-block accumulation memory using saturating signed read-modify-write. It also provides a registered readback port and commit statistics, so that benches and the bandwidth monitor see realistic backpressure on the write channel.

---
 rtl/gradient_mem_write_responder.sv | 151 +++++++++++++++
 tb/tb_gradient_mem_write_responder.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gradient_mem_write_responder.sv
// Ingress FIFO for gradient writes, drained at a programmable rate into an
// on-block accumulation memory with saturating signed read-modify-write.
module gradient_mem_write_responder #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int DRAIN_INTERVAL = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            mem_valid,
    output logic                            mem_ready,
    input  logic [ADDR_W-1:0]               mem_addr,
    input  logic [DATA_W-1:0]               mem_data,
    input  logic                            drain_en,
    input  logic [ADDR_W-1:0]               rd_addr,
    output logic [DATA_W-1:0]               rd_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [31:0]                     accepted_count,
    output logic [31:0]                     committed_count,
    output logic [31:0]                     sat_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = (DRAIN_INTERVAL > 1) ? $clog2(DRAIN_INTERVAL) : 1;
    localparam int WORDS = 1 << ADDR_W;

    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(DRAIN_INTERVAL - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] mem_d [WORDS];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [31:0]       acc_cnt_q, acc_cnt_d;
    logic [31:0]       com_cnt_q, com_cnt_d;
    logic [31:0]       sat_cnt_q, sat_cnt_d;

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W:0]   sum;
    logic              ovf;
    logic [DATA_W-1:0] sat_val;

    // Ready depends only on registered level, so a drain never frees a full slot early.
    assign mem_ready = (level_q != FULL_LVL);
    assign push      = mem_valid && mem_ready;
    assign pop       = (level_q != '0) && drain_en && (gap_q == '0);

    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];
    assign cur_word  = mem_q[head_addr];

    // One extra bit catches overflow: top two bits disagree on a clamp.
    assign sum     = {cur_word[DATA_W-1], cur_word} + {head_data[DATA_W-1], head_data};
    assign ovf     = sum[DATA_W] != sum[DATA_W-1];
    assign sat_val = !ovf ? sum[DATA_W-1:0] : (sum[DATA_W] ? SAT_MIN : SAT_MAX);

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        acc_cnt_d   = acc_cnt_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = mem_addr;
            fifo_data_d[wr_ptr_q] = mem_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            acc_cnt_d             = acc_cnt_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        mem_d     = mem_q;
        gap_d     = gap_q;
        com_cnt_d = com_cnt_q;
        sat_cnt_d = sat_cnt_q;
        rd_data_d = mem_q[rd_addr];
        if (pop) begin
            mem_d[head_addr] = sat_val;
            gap_d            = GAP_LOAD;
            com_cnt_d        = com_cnt_q + 32'd1;
            if (ovf) begin
                sat_cnt_d = sat_cnt_q + 32'd1;
            end
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            gap_q     <= '0;
            rd_data_q <= '0;
            acc_cnt_q <= '0;
            com_cnt_q <= '0;
            sat_cnt_q <= '0;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            gap_q     <= gap_d;
            rd_data_q <= rd_data_d;
            acc_cnt_q <= acc_cnt_d;
            com_cnt_q <= com_cnt_d;
            sat_cnt_q <= sat_cnt_d;
            mem_q     <= mem_d;
        end
    end

    assign rd_data         = rd_data_q;
    assign fifo_level      = level_q;
    assign accepted_count  = acc_cnt_q;
    assign committed_count = com_cnt_q;
    assign sat_count       = sat_cnt_q;

endmodule

// File: tb/tb_gradient_mem_write_responder.sv
// Bench for gradient_mem_write_responder: directed scenarios plus a random run
// against a queue-based reference model of the write/accumulate behaviour.
module tb_gradient_mem_write_responder;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        mem_valid = 1'b0;
    logic [7:0]  mem_addr = '0;
    logic [15:0] mem_data = '0;
    logic        drain_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        mem_ready;
    logic [15:0] rd_data;
    logic [2:0]  fifo_level;
    logic [31:0] acc_cnt, com_cnt, sat_cnt;

    logic        v3 = 1'b0;
    logic [7:0]  a3 = '0;
    logic [15:0] d3 = '0;
    logic        den3 = 1'b0;
    logic [7:0]  ra3 = '0;
    logic        ready3;
    logic [15:0] rd3;
    logic [2:0]  lvl3;
    logic [31:0] acc3, com3, sat3;

    gradient_mem_write_responder #(
        .ADDR_W(8), .DATA_W(16), .FIFO_DEPTH(DEPTH), .DRAIN_INTERVAL(1)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .drain_en(drain_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .fifo_level(fifo_level), .accepted_count(acc_cnt),
        .committed_count(com_cnt), .sat_count(sat_cnt)
    );

    gradient_mem_write_responder #(
        .ADDR_W(8), .DATA_W(16), .FIFO_DEPTH(DEPTH), .DRAIN_INTERVAL(3)
    ) dut3 (
        .clock(clock), .reset(reset),
        .mem_valid(v3), .mem_ready(ready3),
        .mem_addr(a3), .mem_data(d3),
        .drain_en(den3), .rd_addr(ra3), .rd_data(rd3),
        .fifo_level(lvl3), .accepted_count(acc3),
        .committed_count(com3), .sat_count(sat3)
    );

    typedef struct {
        logic [7:0] a;
        int         d;
    } ent_t;

    ent_t q[$];
    int   m [256];
    int   m_acc, m_com, m_sat, m_rd, cyc, last_dr;
    int   checks = 0;
    int   errors = 0;

    // Model: a drain may happen once at least one full interval has elapsed.
    task automatic tick();
        bit   rdy, acc, drn;
        ent_t e;
        int   s;
        rdy  = q.size() != DEPTH;
        acc  = mem_valid && rdy;
        drn  = (q.size() != 0) && drain_en && (cyc - last_dr >= 1);
        m_rd = m[rd_addr];
        if (drn) begin
            e = q.pop_front();
            s = m[e.a] + e.d;
            if (s > 32767) begin
                s = 32767;
                m_sat++;
            end else if (s < -32768) begin
                s = -32768;
                m_sat++;
            end
            m[e.a] = s;
            m_com++;
            last_dr = cyc;
        end
        if (acc) begin
            e.a = mem_addr;
            e.d = int'($signed(mem_data));
            q.push_back(e);
            m_acc++;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_valid = 1'b0;
        v3        = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        q.delete();
        foreach (m[i]) m[i] = 0;
        m_acc   = 0;
        m_com   = 0;
        m_sat   = 0;
        m_rd    = 0;
        cyc     = 0;
        last_dr = -8;
    endtask

    task automatic write1(input logic [7:0] a, input logic [15:0] d);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_data  = d;
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", mem_ready);
        end
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_level got %0d want 0", fifo_level);
        end
        checks++;
        if (rd_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_rd got %0d want 0", rd_data);
        end
        checks++;
        if ({acc_cnt, com_cnt, sat_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", acc_cnt, com_cnt, sat_cnt);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        drain_en = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = 8'h05;
        mem_data  = 16'd100;
        tick();
        tick();
        mem_valid = 1'b0;
        tick();
        rd_addr = 8'h05;
        tick();
        checks++;
        if (rd_data !== 16'd200) begin
            errors++;
            $display("FAIL single_mem5 got %0d want 200", $signed(rd_data));
        end
        checks++;
        if (acc_cnt !== 32'd2 || com_cnt !== 32'd2 || sat_cnt !== 32'd0) begin
            errors++;
            $display("FAIL single_counts got %0d/%0d/%0d want 2/2/0", acc_cnt, com_cnt, sat_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drain_en  = 1'b0;
        mem_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_addr = 8'(8'h20 + i);
            mem_data = 16'(11 * (i + 1));
            tick();
        end
        mem_valid = 1'b0;
        checks++;
        if (acc_cnt !== 32'd4 || mem_ready !== 1'b0 || fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL bp_full got acc=%0d rdy=%b lvl=%0d want 4/0/4", acc_cnt, mem_ready, fifo_level);
        end
        drain_en = 1'b1;
        rd_addr  = 8'h20;
        tick();
        checks++;
        if (mem_ready !== 1'b1 || com_cnt !== 32'd1) begin
            errors++;
            $display("FAIL bp_reassert got rdy=%b com=%0d want 1/1", mem_ready, com_cnt);
        end
        // Reading the previous commit's address exposes any reordering.
        for (int k = 1; k <= 4; k++) begin
            rd_addr = 8'(8'h20 + k - 1);
            tick();
            checks++;
            if (rd_data !== 16'(11 * k)) begin
                errors++;
                $display("FAIL bp_order%0d got %0d want %0d", k, rd_data, 11 * k);
            end
        end
        checks++;
        if (com_cnt !== 32'd4) begin
            errors++;
            $display("FAIL bp_commits got %0d want 4", com_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drain_en = 1'b1;
        write1(8'h10, 16'sd30000);
        write1(8'h10, 16'sd10000);
        rd_addr = 8'h10;
        idle(3);
        checks++;
        if (rd_data !== 16'h7fff || sat_cnt !== 32'd1) begin
            errors++;
            $display("FAIL sat_pos got %0d sat=%0d want 32767 sat=1", $signed(rd_data), sat_cnt);
        end
        for (int i = 0; i < 3; i++) write1(8'h10, 16'h8000);
        idle(3);
        checks++;
        if (rd_data !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg got %0d want -32768", $signed(rd_data));
        end
        // 32767-32768=-1 fits; the next two adds both clamp at the minimum.
        checks++;
        if (sat_cnt !== 32'd3 || sat_cnt !== 32'(m_sat)) begin
            errors++;
            $display("FAIL sat_count got %0d want 3 model %0d", sat_cnt, m_sat);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        drain_en = 1'b0;
        write1(8'h30, 16'd1);
        write1(8'h31, 16'd2);
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL pp_pre got %0d want 2", fifo_level);
        end
        drain_en = 1'b1;
        write1(8'h32, 16'd3);
        checks++;
        if (fifo_level !== 3'd2 || acc_cnt !== 32'd3 || com_cnt !== 32'd1) begin
            errors++;
            $display("FAIL pp_post got lvl=%0d acc=%0d com=%0d want 2/3/1", fifo_level, acc_cnt, com_cnt);
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drain_en = 1'b1;
        write1(8'h07, 16'd50);
        idle(2);
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) write1(8'h07, 16'd1);
        rd_addr = 8'h07;
        tick();
        checks++;
        if (fifo_level !== 3'd3 || rd_data !== 16'd50) begin
            errors++;
            $display("FAIL mid_pre got lvl=%0d rd=%0d want 3/50", fifo_level, rd_data);
        end
        do_reset();
        checks++;
        if (fifo_level !== 3'd0 || mem_ready !== 1'b1 || {acc_cnt, com_cnt, sat_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL mid_state got lvl=%0d rdy=%b cnt=%0d/%0d/%0d want 0/1/0", fifo_level, mem_ready, acc_cnt, com_cnt, sat_cnt);
        end
        drain_en = 1'b1;
        idle(5);
        checks++;
        if (rd_data !== 16'd0 || com_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_stale got rd=%0d com=%0d want 0/0", rd_data, com_cnt);
        end
    endtask

    task automatic test_rate_limit();
        int c, i, ncom, first_acc;
        int edges [8];
        bit acc_now, saw_low;
        logic [31:0] prev;
        do_reset();
        den3      = 1'b1;
        c         = 0;
        i         = 0;
        ncom      = 0;
        first_acc = -1;
        saw_low   = 1'b0;
        prev      = '0;
        while (ncom < 8 && c < 60) begin
            v3 = (i < 8);
            a3 = 8'(8'h40 + i);
            d3 = 16'(i * 7 + 3);
            acc_now = v3 && ready3;
            if (!ready3) saw_low = 1'b1;
            if (acc_now && first_acc < 0) first_acc = c;
            tick();
            if (acc_now) i++;
            if (com3 != prev) begin
                edges[ncom] = c;
                ncom++;
                prev = com3;
            end
            c++;
        end
        v3 = 1'b0;
        checks++;
        if (ncom != 8 || acc3 !== 32'd8 || com3 !== 32'd8) begin
            errors++;
            $display("FAIL rate_total got commits=%0d acc=%0d com=%0d want 8/8/8", ncom, acc3, com3);
        end
        checks++;
        if (ncom > 0 && edges[0] != first_acc + 1) begin
            errors++;
            $display("FAIL rate_latency got %0d want %0d", edges[0], first_acc + 1);
        end
        for (int k = 1; k < ncom; k++) begin
            checks++;
            if (edges[k] - edges[k-1] != 3) begin
                errors++;
                $display("FAIL rate_gap%0d got %0d want 3", k, edges[k] - edges[k-1]);
            end
        end
        checks++;
        if (!saw_low) begin
            errors++;
            $display("FAIL rate_ready got no deassert want deassert");
        end
        for (int k = 0; k < 8; k++) begin
            ra3 = 8'(8'h40 + k);
            tick();
            checks++;
            if (rd3 !== 16'(k * 7 + 3)) begin
                errors++;
                $display("FAIL rate_mem%0d got %0d want %0d", k, rd3, k * 7 + 3);
            end
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_addr  = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0)
                mem_data = 16'($urandom);
            else
                mem_data = 16'($signed($urandom_range(0, 600)) - 300);
            drain_en = ($urandom_range(0, 9) < 7);
            rd_addr  = 8'($urandom_range(0, 7));
            tick();
            checks++;
            if (mem_ready !== (q.size() != DEPTH) || fifo_level !== 3'(q.size())) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL rnd_fifo got rdy=%b lvl=%0d want lvl=%0d", mem_ready, fifo_level, q.size());
            end
            checks++;
            if (rd_data !== 16'(m_rd)) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL rnd_rd got %0d want %0d", $signed(rd_data), m_rd);
            end
            checks++;
            if (acc_cnt !== 32'(m_acc) || com_cnt !== 32'(m_com) || sat_cnt !== 32'(m_sat)) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL rnd_cnt got %0d/%0d/%0d want %0d/%0d/%0d", acc_cnt, com_cnt, sat_cnt, m_acc, m_com, m_sat);
            end
        end
        mem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_saturation();
        test_push_pop();
        test_reset_mid();
        test_rate_limit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
